// File: rtl/ram_stream_writer.sv
// Stream-to-RAM loader: writes a valid/ready word stream into an internal
// RAM starting at base_addr, with a registered independent read port.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   start, abort       load request (IDLE only) / cancel active load
//   base_addr, length  first address and word count, latched on start
//   in_data, in_valid  stream word and its qualifier
//   in_ready           word accepted this cycle when in_valid is high
//   busy, done         load in progress / one-cycle completion pulse
//   wr_count           words written by the current or last load
//   rd_addr, q         read address and registered read data
module ram_stream_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic load_st;
  logic hs;
  logic we;

  assign load_st  = (state_q == S_LOAD);
  assign hs       = load_st && in_valid;
  // Reset suppresses the write that would otherwise coincide with it.
  assign we       = hs && !rst;

  assign in_ready = load_st;
  assign busy     = load_st;
  assign done     = (state_q == S_DONE);
  assign wr_count = cnt_q;
  assign q        = q_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = CNT_ZERO;
          if (length == CNT_ZERO) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = base_addr;
            rem_d   = length;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          ptr_d = ptr_q + PTR_ONE;
          rem_d = rem_q - CNT_ONE;
          cnt_d = cnt_q + CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end
        // Abort wins over completion: no done pulse once aborted.
        if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= mem_q[rd_addr];
    end
  end

  // Contents survive reset; the read above sees pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed self-checking bench for ram_stream_writer.
// Drives inputs #1 after each rising edge and samples there too.
module tb_ram_stream_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [8:0] wr_count;
  logic [7:0] rd_addr;
  logic [7:0] q;

  int total = 0;
  int bad   = 0;

  ram_stream_writer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .length   (length),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .rd_addr  (rd_addr),
    .q        (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] b, input logic [8:0] n);
    start     = 1'b1;
    base_addr = b;
    length    = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] e);
    rd_addr = a;
    tick();
    chk(tag, {24'd0, q}, {24'd0, e});
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    length    = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    rd_addr   = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_cnt", {23'd0, wr_count}, 0);
    chk("rst_q", {24'd0, q}, 0);
    rst = 1'b0;
    tick();

    // Back-to-back load of four words at 0x10
    go(8'h10, 9'd4);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_ready", {31'd0, in_ready}, 1);
    chk("t1_cnt0", {23'd0, wr_count}, 0);
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    chk("t1_ready_lo", {31'd0, in_ready}, 0);
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_cnt", {23'd0, wr_count}, 4);
    tick();
    chk("t1_done_lo", {31'd0, done}, 0);
    chk("t1_idle", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++)
      rd("t1_rd", 8'h10 + 8'(i), 8'hA1 + 8'(i));

    // Wrapping load with gaps in in_valid
    go(8'hFE, 9'd3);
    for (int i = 0; i < 3; i++) begin
      push(8'h11 * 8'(i + 1));
      if (i < 2) begin
        tick();
        tick();
        chk("t2_gap_ready", {31'd0, in_ready}, 1);
        chk("t2_gap_done", {31'd0, done}, 0);
      end
    end
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_cnt", {23'd0, wr_count}, 3);
    tick();
    chk("t2_done_lo", {31'd0, done}, 0);
    rd("t2_fe", 8'hFE, 8'h11);
    rd("t2_ff", 8'hFF, 8'h22);
    rd("t2_00", 8'h00, 8'h33);

    // Zero-length request
    go(8'h10, 9'd0);
    chk("t3_ready", {31'd0, in_ready}, 0);
    chk("t3_done", {31'd0, done}, 1);
    chk("t3_cnt", {23'd0, wr_count}, 0);
    tick();
    chk("t3_done_lo", {31'd0, done}, 0);
    rd("t3_mem", 8'h10, 8'hA1);

    // Preload 0x40..0x47, then abort a reload after three words
    go(8'h40, 9'd8);
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    tick();
    go(8'h40, 9'd8);
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    go(8'h80, 9'd1);
    chk("t4_busy", {31'd0, busy}, 1);
    chk("t4_cnt3", {23'd0, wr_count}, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_busy", {31'd0, busy}, 0);
    chk("t4_abort_done", {31'd0, done}, 0);
    chk("t4_cnt", {23'd0, wr_count}, 3);
    tick();
    chk("t4_no_done", {31'd0, done}, 0);
    for (int i = 0; i < 8; i++)
      rd("t4_rd", 8'h40 + 8'(i),
         (i < 3) ? 8'h70 + 8'(i) : 8'h60 + 8'(i));

    // Read-before-write on the same address
    go(8'h20, 9'd1);
    push(8'h00);
    tick();
    go(8'h20, 9'd1);
    rd_addr = 8'h20;
    push(8'h55);
    chk("t5_old", {24'd0, q}, 8'h00);
    tick();
    chk("t5_new", {24'd0, q}, 8'h55);
    tick();

    // Reset mid-load, then a fresh load (abort in IDLE ignored)
    go(8'h50, 9'd4);
    push(8'hB1);
    push(8'hB2);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("t6_ready", {31'd0, in_ready}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_cnt", {23'd0, wr_count}, 0);
    chk("t6_q", {24'd0, q}, 0);
    tick();
    chk("t6_no_done", {31'd0, done}, 0);
    rd("t6_50", 8'h50, 8'hB1);
    rd("t6_51", 8'h51, 8'hB2);
    abort = 1'b1;
    go(8'h52, 9'd2);
    abort = 1'b0;
    chk("t6_restart", {31'd0, busy}, 1);
    push(8'hC1);
    push(8'hC2);
    chk("t6_done2", {31'd0, done}, 1);
    chk("t6_cnt2", {23'd0, wr_count}, 2);
    tick();
    rd("t6_52", 8'h52, 8'hC1);
    rd("t6_53", 8'h53, 8'hC2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
